// File: rtl/counter_pkg.sv
// Shared types for the modulo-N up/down counter.
// Direction encoding and the per-edge operation select.
package counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_LOAD,
    CNT_STEP
  } cnt_op_t;

endpackage

// File: rtl/mod_count_next.sv
// Combinational next-count for the modulo-N counter.
// Works in WIDTH+1 bits so load clamping never aliases.
module mod_count_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] count,
  input  cnt_op_t          op,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next,
  output logic             at_bound
);

  localparam logic [WIDTH:0] MAX  = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ZERO = '0;
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] lv_x;
  logic [WIDTH:0] nxt_x;

  assign cnt_x = {1'b0, count};
  assign lv_x  = {1'b0, load_val};

  // Bound detection and next value for the selected operation.
  always_comb begin
    at_bound = (up_dn == DIR_UP) ? (cnt_x == MAX)
                                 : (cnt_x == ZERO);
    nxt_x = cnt_x;
    unique case (op)
      CNT_LOAD: begin
        nxt_x = (lv_x > MAX) ? MAX : lv_x;
      end
      CNT_STEP: begin
        if (at_bound) begin
          if (SATURATE)
            nxt_x = cnt_x;
          else
            nxt_x = (up_dn == DIR_UP) ? ZERO : MAX;
        end else begin
          nxt_x = (up_dn == DIR_UP) ? cnt_x + ONE
                                    : cnt_x - ONE;
        end
      end
      CNT_HOLD: nxt_x = cnt_x;
      default:  nxt_x = cnt_x;
    endcase
  end

  assign next = nxt_x[WIDTH-1:0];

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with load,
// wrap/saturate, terminal-count pulse and sticky overflow.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
    $fatal(1, "mod_updown_counter: MODULUS out of range");
  end

  cnt_op_t          op;
  logic [WIDTH-1:0] next;
  logic             at_bound;
  logic             hit;

  // Load outranks enable; otherwise hold.
  always_comb begin
    if (load)
      op = CNT_LOAD;
    else if (en)
      op = CNT_STEP;
    else
      op = CNT_HOLD;
  end

  assign hit = (op == CNT_STEP) && at_bound;

  mod_count_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .count   (count),
    .op      (op),
    .up_dn   (up_dn),
    .load_val(load_val),
    .next    (next),
    .at_bound(at_bound)
  );

  // Register count, tc and ovf; a new hit beats clr_ovf.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= next;
      tc    <= hit;
      ovf   <= hit | (ovf & ~clr_ovf);
    end
  end

endmodule
